// File: rtl/meatsquare_datapath.sv
// Falling-square datapath: holds the square position, runs the frame delay
// counter and walks the square's pixels into the VGA adapter write port.
module meatsquare_datapath #(
  parameter int          SIZE        = 4,
  parameter int          X_W         = 8,
  parameter int          Y_W         = 7,
  parameter int          SCREEN_H    = 120,
  parameter int          START_X     = 78,
  parameter int          START_Y     = 0,
  parameter int          STEP        = 1,
  parameter int          FRAME_DELAY = 833333,
  parameter int          C_W         = 20,
  parameter logic [2:0]  SQ_COLOUR   = 3'b100,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           update,
  input  logic           plot,
  input  logic           draw,
  input  logic           erase,
  input  logic           reset_count,
  output logic           finish_counting,
  output logic           finish_game,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot,
  output logic           busy
);

  localparam int             P_W   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int             YW1   = Y_W + 1;
  localparam logic [P_W-1:0] LAST  = P_W'(SIZE - 1);
  localparam logic [X_W-1:0] POS_X = X_W'(START_X);
  localparam logic [YW1-1:0] LIMIT = YW1'(SCREEN_H);
  localparam logic [YW1-1:0] REACH = YW1'(SIZE + STEP);

  typedef enum logic {IDLE, WALK} state_t;

  state_t         state;
  logic [Y_W-1:0] pos_y;
  logic [C_W-1:0] count;
  logic [X_W-1:0] bx;
  logic [Y_W-1:0] by;
  logic [P_W-1:0] cx, cy;
  logic [P_W-1:0] nx, ny;
  logic           mode;
  logic           command;
  logic [YW1-1:0] bottom;

  // One extra bit so the bottom edge comparison cannot wrap near SCREEN_H.
  assign bottom          = {1'b0, pos_y} + REACH;
  assign finish_game     = bottom > LIMIT;
  assign finish_counting = (count == '0);
  assign command         = plot && (draw ^ erase);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pos_y <= Y_W'(START_Y);
    end else if (update && !finish_game) begin
      pos_y <= pos_y + Y_W'(STEP);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (reset_count) begin
      count <= C_W'(FRAME_DELAY - 1);
    end else if (count != '0) begin
      count <= count - C_W'(1);
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    nx = cx + P_W'(1);
    ny = cy;
    if (cx == LAST) begin
      nx = '0;
      ny = cy + P_W'(1);
    end
  end

  // The first pixel is registered in the command cycle itself, so cx/cy
  // always name the pixel currently presented on vga_*.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      bx         <= '0;
      by         <= '0;
      cx         <= '0;
      cy         <= '0;
      mode       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (command) begin
            state      <= WALK;
            bx         <= POS_X;
            by         <= pos_y;
            mode       <= draw;
            cx         <= '0;
            cy         <= '0;
            vga_x      <= POS_X;
            vga_y      <= pos_y;
            vga_colour <= draw ? SQ_COLOUR : BG_COLOUR;
            vga_plot   <= 1'b1;
            busy       <= 1'b1;
          end
        end
        WALK: begin
          if (cx == LAST && cy == LAST) begin
            state    <= IDLE;
            vga_plot <= 1'b0;
            busy     <= 1'b0;
          end else begin
            cx         <= nx;
            cy         <= ny;
            vga_x      <= bx + X_W'(nx);
            vga_y      <= by + Y_W'(ny);
            vga_colour <= mode ? SQ_COLOUR : BG_COLOUR;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_meatsquare_datapath.sv
// Scoreboard bench for meatsquare_datapath: stimulus queues expected pixels,
// a negedge monitor pops and compares them whenever vga_plot is high.
module tb_meatsquare_datapath;

  localparam int SIZE        = 4;
  localparam int FRAME_DELAY = 20;
  localparam int X0          = 78;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       update = 1'b0, plot = 1'b0, draw = 1'b0, erase = 1'b0, reset_count = 1'b0;
  logic       finish_counting, finish_game, vga_plot, busy;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pixel_t;

  pixel_t exp_q[$];
  int     vectors     = 0;
  int     miscompares = 0;

  meatsquare_datapath #(
    .SIZE(SIZE), .FRAME_DELAY(FRAME_DELAY), .C_W(5)
  ) dut (
    .clock(clock), .reset(reset), .update(update), .plot(plot), .draw(draw),
    .erase(erase), .reset_count(reset_count), .finish_counting(finish_counting),
    .finish_game(finish_game), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Queue the first n pixels of a square whose top-left is (X0, y).
  task automatic expect_square(input int y, input logic [2:0] c, input int n);
    pixel_t p;
    for (int k = 0; k < n; k++) begin
      p.x = 8'(X0 + k % SIZE);
      p.y = 7'(y + k / SIZE);
      p.c = c;
      exp_q.push_back(p);
    end
  endtask

  task automatic command(input logic d, input logic e);
    plot = 1'b1; draw = d; erase = e;
    tick();
    plot = 1'b0; draw = 1'b0; erase = 1'b0;
  endtask

  // Called right after the command edge: busy must cover exactly SIZE*SIZE cycles.
  task automatic walk_check(input string name);
    for (int i = 0; i < SIZE * SIZE; i++) begin
      check({name, " busy during walk"}, busy, 1);
      tick();
    end
    check({name, " busy after walk"}, busy, 0);
    check({name, " pixels outstanding"}, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40 && busy === 1'b1; i++) tick();
    check({name, " busy timeout"}, busy, 0);
  endtask

  task automatic pulse_update();
    update = 1'b1;
    tick();
    update = 1'b0;
    tick();
  endtask

  initial begin : monitor
    pixel_t p;
    forever begin
      @(negedge clock);
      if (vga_plot === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected pixel: got x=%0d y=%0d c=%0b, expected no plot",
                   vga_x, vga_y, vga_colour);
        end else begin
          p = exp_q.pop_front();
          if ({vga_x, vga_y, vga_colour} !== p) begin
            miscompares++;
            $display("FAIL pixel: got x=%0d y=%0d c=%0b, expected x=%0d y=%0d c=%0b",
                     vga_x, vga_y, vga_colour, p.x, p.y, p.c);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    // Reset state
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("reset finish_counting", finish_counting, 1);
    check("reset finish_game", finish_game, 0);
    check("reset vga_plot", vga_plot, 0);
    check("reset busy", busy, 0);
    check("reset vga_x", vga_x, 0);
    check("reset vga_y", vga_y, 0);

    // Draw walk at the start position
    expect_square(0, 3'b100, 16);
    command(1'b1, 1'b0);
    walk_check("draw@0");

    // Frame delay counter, then a reload part way through
    reset_count = 1'b1; tick(); reset_count = 1'b0;
    for (int i = 0; i < FRAME_DELAY - 1; i++) begin
      check("count running", finish_counting, 0);
      tick();
    end
    check("count expired", finish_counting, 1);
    reset_count = 1'b1; tick(); reset_count = 1'b0;
    repeat (9) tick();
    check("count before reload", finish_counting, 0);
    reset_count = 1'b1; tick(); reset_count = 1'b0;
    for (int i = 0; i < FRAME_DELAY - 1; i++) begin
      check("count after reload", finish_counting, 0);
      tick();
    end
    check("count reload expired", finish_counting, 1);

    // Erase walk with an update and an ignored draw during it
    expect_square(0, 3'b000, 16);
    command(1'b0, 1'b1);
    tick();
    tick();
    update = 1'b1; tick(); update = 1'b0;
    tick();
    plot = 1'b1; draw = 1'b1; tick(); plot = 1'b0; draw = 1'b0;
    wait_idle("erase");
    check("erase pixels outstanding", exp_q.size(), 0);
    expect_square(1, 3'b100, 16);
    command(1'b1, 1'b0);
    walk_check("draw@1");

    // Reset aborts a walk after seven pixels
    expect_square(1, 3'b100, 7);
    command(1'b1, 1'b0);
    repeat (6) tick();
    reset = 1'b0;
    tick();
    check("abort vga_plot", vga_plot, 0);
    check("abort busy", busy, 0);
    check("abort vga_x", vga_x, 0);
    check("abort pixels outstanding", exp_q.size(), 0);
    reset = 1'b1;
    tick();

    // Draw and erase together is not a command
    plot = 1'b1; draw = 1'b1; erase = 1'b1; tick();
    plot = 1'b0; draw = 1'b0; erase = 1'b0;
    repeat (4) tick();
    check("both-high busy", busy, 0);
    check("both-high vga_plot", vga_plot, 0);
    expect_square(0, 3'b100, 16);
    command(1'b1, 1'b0);
    walk_check("draw after reset");

    // Fall to the bottom of the screen
    for (int i = 0; i < 116; i++) begin
      if (i == 115) check("finish_game at y=115", finish_game, 0);
      pulse_update();
    end
    check("finish_game at y=116", finish_game, 1);
    pulse_update();
    check("finish_game held", finish_game, 1);
    expect_square(116, 3'b100, 16);
    command(1'b1, 1'b0);
    walk_check("draw@116");

    check("final pixels outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/meatsquare_datapath.md
Name: meatsquare_datapath

Overview:
Datapath stage driven by the game control FSM. It consumes the control pulses update, plot, draw, erase and reset_count, and produces the status flags finish_counting and finish_game. It holds the falling square's position, runs the per-frame delay counter, and walks the SIZE x SIZE pixels of the square into the VGA adapter's write port.

Parameters:
SIZE, 4, square edge in pixels (2..8)
X_W, 8, VGA x coordinate width
Y_W, 7, VGA y coordinate width
SCREEN_H, 120, screen height in pixels
START_X, 78, square left column after reset
START_Y, 0, square top row after reset
STEP, 1, rows moved per update
FRAME_DELAY, 833333, clock cycles per frame wait (50 MHz / 60 Hz)
C_W, 20, delay counter width (must hold FRAME_DELAY-1)
SQ_COLOUR, 3'b100, draw colour
BG_COLOUR, 3'b000, erase colour

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
update  in  1  one-cycle pulse: advance the square
plot  in  1  pixel command strobe
draw  in  1  with plot: paint the square in SQ_COLOUR
erase  in  1  with plot: paint the square in BG_COLOUR
reset_count  in  1  one-cycle pulse: reload the frame delay counter
finish_counting  out  1  frame delay expired
finish_game  out  1  square cannot move further down
vga_x  out  X_W  pixel column
vga_y  out  Y_W  pixel row
vga_colour  out  3  pixel colour
vga_plot  out  1  pixel write enable
busy  out  1  pixel walk in progress

Behaviour:
- Reset (reset==0 at a clock edge):
  - pos_x=START_X, pos_y=START_Y, count=0, plotter IDLE.
  - vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, busy=0.
  - Reset takes priority over every other input and aborts a walk in progress.
- Position:
  - finish_game is combinational: 1 iff pos_y+SIZE+STEP > SCREEN_H, evaluated at Y_W+1 bits. It is valid in the same cycle as update, because the FSM samples it in its update state.
  - On update with finish_game=0: pos_y <= pos_y+STEP.
  - On update with finish_game=1: pos_y holds.
  - pos_x is constant.
- Delay counter:
  - On reset_count: count <= FRAME_DELAY-1.
  - Otherwise, if count != 0: count decrements by 1 per cycle.
  - finish_counting = (count==0), combinational. It is 1 after reset, which is harmless because the FSM samples it only after issuing reset_count.
  - reset_count during a count reloads the counter.
- Plotter FSM, states IDLE and WALK:
  - IDLE: a command is plot==1 with exactly one of draw/erase high.
    - On a command: latch bx=pos_x, by=pos_y and mode (draw/erase); set cx=0, cy=0; go to WALK.
    - plot with draw and erase both high, or both low, is ignored.
  - WALK, each cycle:
    - Registered outputs: vga_plot=1, vga_x=bx+cx, vga_y=by+cy, vga_colour = draw ? SQ_COLOUR : BG_COLOUR.
    - cx increments. When cx wraps from SIZE-1 to 0, cy increments.
    - After pixel (SIZE-1, SIZE-1): return to IDLE, and vga_plot=0 on the following cycle.
  - Latency: the first pixel appears on vga_* the cycle after the command cycle. Exactly SIZE*SIZE consecutive vga_plot cycles, in row-major order.
  - busy=1 for exactly the SIZE*SIZE WALK cycles.
  - A command arriving while busy=1 is ignored (not queued).
  - The FSM leaves draw for count after one cycle. The walk therefore runs concurrently with the delay count; FRAME_DELAY > SIZE*SIZE is required.
  - An update during a walk moves pos_y, but the walk keeps its latched base, so there is no tearing.
- Width rules:
  - vga_x and vga_y are truncated to X_W and Y_W.
  - Parameters guarantee no overflow: START_X+SIZE <= 2^X_W and SCREEN_H <= 2^Y_W.
- While vga_plot=0, vga_x, vga_y and vga_colour hold their last values.

Test Plan:
1. Reset, then release; FRAME_DELAY=20 -> finish_counting=1, finish_game=0, pos_y=0, vga_plot=0, busy=0.
2. plot+draw pulse at cycle T -> vga_plot=1 for cycles T+1..T+16. First pixel (78,0) colour 3'b100, last pixel (81,3). busy falls after T+16.
3. reset_count pulse -> finish_counting=0 for 19 cycles, then 1. A second reset_count at cycle 10 delays expiry to 19 cycles after the second pulse.
4. Issue 116 update pulses -> pos_y=116, finish_game=1. A further update leaves pos_y=116 (116+4+1 > 120).
5. plot+erase at T, update at T+3, plot+draw at T+5 -> erase walk completes all 16 pixels at the old y in colour 3'b000. The draw at T+5 is ignored. A next draw after busy falls paints at y+1.
6. Reset low at walk pixel 7 -> next cycle vga_plot=0, busy=0, pos_y=0. plot with draw and erase both high -> no vga_plot.
